// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: PC control, program-memory read, IR issue and redirect.
// master = fetch unit side, slave = PC / memory / decoder / execute side.
interface fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0]   pc_in;
    logic                pc_step;
    logic                pc_control;
    logic [ADDR_W-1:0]   pc_din;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;
    logic                ir_valid;
    logic                ir_ready;
    logic [DATA_W/2-1:0] ir_opcode;
    logic [DATA_W/2-1:0] ir_operand;
    logic                redir_valid;
    logic [ADDR_W-1:0]   redir_target;

    modport master (
        input  pc_in,
        output pc_step, pc_control, pc_din,
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output ir_valid, ir_opcode, ir_operand,
        input  ir_ready,
        input  redir_valid, redir_target
    );

    modport slave (
        output pc_in,
        input  pc_step, pc_control, pc_din,
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  ir_valid, ir_opcode, ir_operand,
        output ir_ready,
        output redir_valid, redir_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads program memory at the PC, steers the PC, issues IR to decode.
//   state   | meaning
//   S_RST   | load RESET_VEC into the PC
//   S_FETCH | request the opcode byte at pc_in
//   S_TGT   | request the JMP target byte, load it into the PC
//   S_ISSUE | IR presented to the decoder until accepted
module fetch_unit #(
    parameter int                  ADDR_W    = 8,
    parameter int                  DATA_W    = 8,
    parameter logic [DATA_W/2-1:0] JMP_OP    = 'hF,
    parameter logic [ADDR_W-1:0]   RESET_VEC = '0
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    typedef enum logic [1:0] {S_RST, S_FETCH, S_TGT, S_ISSUE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              pc_step, pc_control, mem_req;
    logic [ADDR_W-1:0] pc_din;

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_step    = 1'b0;
        pc_control = 1'b0;
        pc_din     = '0;
        mem_req    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_RST: begin
                    pc_step    = 1'b1;
                    pc_control = 1'b1;
                    pc_din     = RESET_VEC;
                    state_d    = S_FETCH;
                end
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (bus.mem_ack) begin
                        ir_d    = bus.mem_rdata;
                        pc_step = 1'b1;
                        state_d = (bus.mem_rdata[DATA_W-1:DATA_W/2] == JMP_OP) ? S_TGT : S_ISSUE;
                    end
                end
                S_TGT: begin
                    mem_req = 1'b1;
                    if (bus.mem_ack) begin
                        pc_step    = 1'b1;
                        pc_control = 1'b1;
                        pc_din     = ADDR_W'(bus.mem_rdata);
                        state_d    = S_FETCH;
                    end
                end
                S_ISSUE: begin
                    if (bus.ir_ready) state_d = S_FETCH;
                end
                default: state_d = S_RST;
            endcase
            // Redirect wins over any ack this cycle; the request is withdrawn.
            if (bus.redir_valid && state_q != S_RST) begin
                mem_req    = 1'b0;
                pc_step    = 1'b1;
                pc_control = 1'b1;
                pc_din     = bus.redir_target;
                ir_d       = ir_q;
                state_d    = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RST;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.pc_step    = pc_step;
    assign bus.pc_control = pc_control;
    assign bus.pc_din     = pc_din;
    assign bus.mem_req    = mem_req;
    assign bus.mem_addr   = mem_req ? bus.pc_in : '0;
    assign bus.ir_valid   = !rst && (state_q == S_ISSUE);
    assign bus.ir_opcode  = rst ? '0 : ir_q[DATA_W-1:DATA_W/2];
    assign bus.ir_operand = rst ? '0 : ir_q[DATA_W/2-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-side PC register, scripted memory acks, issue scoreboard.
module tb_fetch_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc_q = 8'h5A;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got, want;

    fetch_if #(.ADDR_W(8), .DATA_W(8)) bus();

    fetch_unit #(.ADDR_W(8), .DATA_W(8), .JMP_OP(4'hF), .RESET_VEC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.pc_in = pc_q;
    always @(posedge clk)
        if (bus.pc_step) pc_q <= bus.pc_control ? bus.pc_din : pc_q + 8'd1;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus.mem_ack = 0; bus.mem_rdata = 0; bus.ir_ready = 0;
        bus.redir_valid = 0; bus.redir_target = 0;
        rst = 1;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            settle();
            vectors++;
            if ({bus.pc_step, bus.pc_control, bus.pc_din, bus.mem_req, bus.mem_addr,
                 bus.ir_valid, bus.ir_opcode, bus.ir_operand} !== 28'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: step=%b ctl=%b din=%h req=%b addr=%h v=%b ir=%h%h, want all 0",
                         bus.pc_step, bus.pc_control, bus.pc_din, bus.mem_req, bus.mem_addr,
                         bus.ir_valid, bus.ir_opcode, bus.ir_operand);
            end
            next_cycle();
        end
        rst = 0;
        settle();
        vectors++;
        if ({bus.pc_step, bus.pc_control, bus.pc_din, bus.mem_req} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_exit_load: step=%b ctl=%b din=%h req=%b, want 1 1 00 0",
                     bus.pc_step, bus.pc_control, bus.pc_din, bus.mem_req);
        end
        next_cycle();
        settle();
        vectors++;
        if ({bus.mem_req, bus.mem_addr, bus.pc_step, bus.ir_valid} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_first_req: req=%b addr=%h step=%b v=%b, want 1 00 0 0",
                     bus.mem_req, bus.mem_addr, bus.pc_step, bus.ir_valid);
        end
        next_cycle();
    endtask

    task automatic test_fetch;
        bus.ir_ready = 1;
        settle();
        vectors++;
        if ({bus.mem_req, bus.pc_step} !== 2'b10) begin
            miscompares++;
            $display("FAIL fetch_wait: req=%b step=%b, want 1 0", bus.mem_req, bus.pc_step);
        end
        next_cycle();
        bus.mem_ack = 1; bus.mem_rdata = 8'h35;
        exp_q.push_back(8'h35);
        settle();
        vectors++;
        if ({bus.pc_step, bus.pc_control, bus.mem_req} !== 3'b101) begin
            miscompares++;
            $display("FAIL fetch_step: step=%b ctl=%b req=%b, want 1 0 1",
                     bus.pc_step, bus.pc_control, bus.mem_req);
        end
        next_cycle();
        bus.mem_ack = 0; bus.mem_rdata = 0;
        settle();
        vectors++;
        if ({bus.ir_valid, bus.mem_req} !== 2'b10) begin
            miscompares++;
            $display("FAIL fetch_issue: v=%b req=%b, want 1 0", bus.ir_valid, bus.mem_req);
        end
        if (bus.ir_valid && bus.ir_ready) begin
            vectors++;
            got = {bus.ir_opcode, bus.ir_operand};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL fetch_sb: unexpected issue %h, want none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL fetch_sb: ir=%h, want %h", got, want);
                end
            end
        end
        next_cycle();
        settle();
        vectors++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL fetch_next_addr: req=%b addr=%h, want 1 01", bus.mem_req, bus.mem_addr);
        end
        next_cycle();
    endtask

    task automatic test_backpressure;
        bus.ir_ready = 0;
        bus.mem_ack = 1; bus.mem_rdata = 8'h7A;
        exp_q.push_back(8'h7A);
        settle();
        next_cycle();
        bus.mem_rdata = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            settle();
            vectors++;
            if ({bus.ir_valid, bus.ir_opcode, bus.ir_operand, bus.mem_req, bus.pc_step} !==
                {1'b1, exp_q[0], 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: v=%b ir=%h%h req=%b step=%b, want 1 %h 0 0",
                         i, bus.ir_valid, bus.ir_opcode, bus.ir_operand, bus.mem_req, bus.pc_step, exp_q[0]);
            end
            next_cycle();
        end
        bus.mem_ack = 0; bus.mem_rdata = 0;
        bus.ir_ready = 1;
        settle();
        vectors++;
        got = {bus.ir_opcode, bus.ir_operand};
        want = exp_q.pop_front();
        if ({bus.ir_valid, got} !== {1'b1, want}) begin
            miscompares++;
            $display("FAIL backpressure_sb: v=%b ir=%h, want 1 %h", bus.ir_valid, got, want);
        end
        next_cycle();
    endtask

    task automatic test_jmp;
        bus.redir_valid = 1; bus.redir_target = 8'h10;
        settle();
        next_cycle();
        bus.redir_valid = 0; bus.redir_target = 0;
        bus.mem_ack = 1; bus.mem_rdata = 8'hF0;
        settle();
        vectors++;
        if ({bus.mem_addr, bus.pc_step, bus.pc_control} !== {8'h10, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL jmp_op_fetch: addr=%h step=%b ctl=%b, want 10 1 0",
                     bus.mem_addr, bus.pc_step, bus.pc_control);
        end
        next_cycle();
        bus.mem_ack = 1; bus.mem_rdata = 8'h40;
        settle();
        vectors++;
        if ({bus.ir_valid, bus.mem_req, bus.mem_addr, bus.pc_step, bus.pc_control, bus.pc_din} !==
            {1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h40}) begin
            miscompares++;
            $display("FAIL jmp_target: v=%b req=%b addr=%h step=%b ctl=%b din=%h, want 0 1 11 1 1 40",
                     bus.ir_valid, bus.mem_req, bus.mem_addr, bus.pc_step, bus.pc_control, bus.pc_din);
        end
        next_cycle();
        bus.mem_ack = 0; bus.mem_rdata = 0;
        settle();
        vectors++;
        if ({bus.ir_valid, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 8'h40}) begin
            miscompares++;
            $display("FAIL jmp_next_addr: v=%b req=%b addr=%h, want 0 1 40",
                     bus.ir_valid, bus.mem_req, bus.mem_addr);
        end
        next_cycle();
    endtask

    task automatic test_redirect;
        bus.mem_ack = 1; bus.mem_rdata = 8'h12;
        exp_q.push_back(8'h12);
        settle();
        next_cycle();
        bus.mem_ack = 0; bus.mem_rdata = 0;
        settle();
        vectors++;
        got = {bus.ir_opcode, bus.ir_operand};
        want = exp_q.pop_front();
        if ({bus.ir_valid, got} !== {1'b1, want}) begin
            miscompares++;
            $display("FAIL redirect_pre_sb: v=%b ir=%h, want 1 %h", bus.ir_valid, got, want);
        end
        next_cycle();
        settle();
        next_cycle();
        bus.redir_valid = 1; bus.redir_target = 8'h80;
        bus.mem_ack = 1; bus.mem_rdata = 8'h99;
        settle();
        vectors++;
        if ({bus.mem_req, bus.pc_step, bus.pc_control, bus.pc_din} !== {1'b0, 1'b1, 1'b1, 8'h80}) begin
            miscompares++;
            $display("FAIL redirect_load: req=%b step=%b ctl=%b din=%h, want 0 1 1 80",
                     bus.mem_req, bus.pc_step, bus.pc_control, bus.pc_din);
        end
        next_cycle();
        bus.redir_valid = 0; bus.redir_target = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        settle();
        vectors++;
        if ({bus.ir_valid, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 8'h80}) begin
            miscompares++;
            $display("FAIL redirect_next_addr: v=%b req=%b addr=%h, want 0 1 80",
                     bus.ir_valid, bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack = 1; bus.mem_rdata = 8'h56;
        exp_q.push_back(8'h56);
        next_cycle();
        bus.mem_ack = 0; bus.mem_rdata = 0;
        settle();
        vectors++;
        got = {bus.ir_opcode, bus.ir_operand};
        want = exp_q.pop_front();
        if ({bus.ir_valid, got} !== {1'b1, want}) begin
            miscompares++;
            $display("FAIL redirect_post_sb: v=%b ir=%h, want 1 %h", bus.ir_valid, got, want);
        end
        next_cycle();
    endtask

    task automatic test_wrap;
        bus.redir_valid = 1; bus.redir_target = 8'hFF;
        settle();
        next_cycle();
        bus.redir_valid = 0; bus.redir_target = 0;
        bus.mem_ack = 1; bus.mem_rdata = 8'hF3;
        settle();
        vectors++;
        if ({bus.mem_req, bus.mem_addr, bus.pc_step} !== {1'b1, 8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_jmp_fetch: req=%b addr=%h step=%b, want 1 ff 1",
                     bus.mem_req, bus.mem_addr, bus.pc_step);
        end
        next_cycle();
        bus.mem_rdata = 8'h22;
        settle();
        vectors++;
        if ({bus.mem_addr, bus.pc_control, bus.pc_din} !== {8'h00, 1'b1, 8'h22}) begin
            miscompares++;
            $display("FAIL wrap_target: addr=%h ctl=%b din=%h, want 00 1 22",
                     bus.mem_addr, bus.pc_control, bus.pc_din);
        end
        next_cycle();
        bus.mem_rdata = 8'hF0;
        settle();
        vectors++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 8'h22}) begin
            miscompares++;
            $display("FAIL wrap_next_addr: req=%b addr=%h, want 1 22", bus.mem_req, bus.mem_addr);
        end
        next_cycle();
        bus.mem_ack = 0; bus.mem_rdata = 0;
        settle();
        next_cycle();
        rst = 1;
        bus.mem_ack = 1; bus.mem_rdata = 8'h77;
        settle();
        vectors++;
        if ({bus.pc_step, bus.pc_control, bus.pc_din, bus.mem_req, bus.mem_addr, bus.ir_valid} !== 20'd0) begin
            miscompares++;
            $display("FAIL midtgt_reset_outputs: step=%b ctl=%b din=%h req=%b addr=%h v=%b, want all 0",
                     bus.pc_step, bus.pc_control, bus.pc_din, bus.mem_req, bus.mem_addr, bus.ir_valid);
        end
        next_cycle();
        rst = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        settle();
        vectors++;
        if ({bus.pc_step, bus.pc_control, bus.pc_din} !== {1'b1, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL midtgt_reset_load: step=%b ctl=%b din=%h, want 1 1 00",
                     bus.pc_step, bus.pc_control, bus.pc_din);
        end
        next_cycle();
        settle();
        vectors++;
        if ({bus.mem_req, bus.mem_addr, bus.ir_valid} !== {1'b1, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL midtgt_reset_req: req=%b addr=%h v=%b, want 1 00 0",
                     bus.mem_req, bus.mem_addr, bus.ir_valid);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_backpressure();
        test_jmp();
        test_redirect();
        test_wrap();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
